// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo types: tags, CDB, operands, issue payload
//
// Contents:
//   WORD_W, TAG_W      data word and tag widths
//   tag_t, word        scalar typedefs
//   cdb_t              completion bus {vld, tag, wdata}
//   operand_t          reservation-station operand {rdy, tag, data}
//   issue_t            payload handed to an execution unit {tag, a, b}
//   snoop()            operand update from one CDB broadcast
package tomasulo_pkg;

    localparam int WORD_W = 32;
    localparam int TAG_W  = 6;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [WORD_W-1:0] word;

    typedef struct packed {
        logic vld;
        tag_t tag;
        word  wdata;
    } cdb_t;

    typedef struct packed {
        logic              rdy;
        tag_t              tag;
        logic [WORD_W-1:0] data;
    } operand_t;

    typedef struct packed {
        tag_t tag;
        word  a;
        word  b;
    } issue_t;

    // A pending operand whose tag is on the bus takes the broadcast value;
    // a ready operand is never overwritten. Used both for the dispatch-cycle
    // bypass and for wakeup of stored entries.
    function automatic operand_t snoop(input operand_t op, input cdb_t bus);
        operand_t r;
        r = op;
        if (!op.rdy && bus.vld && (bus.tag == op.tag)) begin
            r.rdy  = 1'b1;
            r.data = bus.wdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/tomasulo_age_select.sv
// rtl/tomasulo_age_select.sv - N-entry age matrix with oldest-requester one-hot grant
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   flush      synchronous clear of the matrix
//   alloc      one-hot: entry becoming valid this cycle (youngest)
//   free       one-hot: entry leaving this cycle
//   req        entries eligible for selection
//   gnt        one-hot: oldest requesting entry (zero when req is zero)
module tomasulo_age_select #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] free,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // younger[i][j] = 1 means entry i was allocated after entry j.
    // Bits pointing at invalid entries may be stale; they are harmless
    // because an invalid entry never requests, and its column is cleared
    // when it is allocated again.
    logic [N-1:0] younger [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) younger[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) younger[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (alloc[j] || free[j]) younger[i][j] <= 1'b0;
                end
                // New entry is younger than everything else; its row
                // assignment overrides the column clear above.
                if (alloc[i]) younger[i] <= ~(N'(1) << i);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[i] & ~(|(younger[i] & req));
        end
    end

endmodule

// File: rtl/tomasulo_rs_mpy.sv
// rtl/tomasulo_rs_mpy.sv - multiply reservation station feeding tomasulo_exe_mpy
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             synchronous clear of all entries and the output stage
//   disp_vld/disp_rdy dispatch handshake; disp_a/disp_b operands
//   disp_tag          tag that the next accepted dispatch will own
//   cdb               completion bus snooped for pending operands
//   iss_vld/iss_rdy   registered issue handshake; iss = {tag, a, b}
//   busy_cnt          number of occupied entries
module tomasulo_rs_mpy
    import tomasulo_pkg::*;
#(
    parameter int N     = 4,
    parameter int RS_ID = 1,
    parameter int IDX_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           disp_vld,
    input  operand_t       disp_a,
    input  operand_t       disp_b,
    output logic           disp_rdy,
    output tag_t           disp_tag,
    input  cdb_t           cdb,
    output logic           iss_vld,
    output issue_t         iss,
    input  logic           iss_rdy,
    output logic [IDX_W:0] busy_cnt
);

    localparam tag_t TAG_BASE = tag_t'(RS_ID << IDX_W);

    logic [N-1:0]     vld;
    operand_t         ent_a [N];
    operand_t         ent_b [N];

    logic [N-1:0]     alloc_oh;
    logic [IDX_W-1:0] alloc_idx;
    logic             disp_fire;
    logic [N-1:0]     alloc_fire;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [N-1:0]     free_oh;
    logic             load;
    logic [IDX_W-1:0] sel_idx;
    word              sel_a;
    word              sel_b;

    // Lowest free entry, taken from the registered valid vector so an entry
    // freed this cycle cannot be handed out until the next one.
    always_comb begin
        alloc_oh  = '0;
        alloc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                alloc_oh  = N'(1) << i;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign disp_rdy   = |(~vld);
    assign disp_tag   = TAG_BASE | tag_t'(alloc_idx);
    assign disp_fire  = disp_vld & disp_rdy & ~flush;
    assign alloc_fire = alloc_oh & {N{disp_fire}};

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = vld[i] & ent_a[i].rdy & ent_b[i].rdy;
        end
    end

    tomasulo_age_select #(.N(N)) u_age (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .alloc (alloc_fire),
        .free  (free_oh),
        .req   (req),
        .gnt   (gnt)
    );

    // Selection only happens when the output stage can take it; during a
    // stall the grant is ignored and nothing leaves the station.
    assign load    = (~iss_vld | iss_rdy) & (|req);
    assign free_oh = gnt & {N{load}};

    always_comb begin
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_idx = IDX_W'(i);
                sel_a   = ent_a[i].data;
                sel_b   = ent_b[i].data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < N; i++) begin
                ent_a[i] <= '0;
                ent_b[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld <= (vld & ~free_oh) | alloc_fire;
            for (int i = 0; i < N; i++) begin
                if (alloc_fire[i]) begin
                    ent_a[i] <= snoop(disp_a, cdb);
                    ent_b[i] <= snoop(disp_b, cdb);
                end else if (vld[i]) begin
                    ent_a[i] <= snoop(ent_a[i], cdb);
                    ent_b[i] <= snoop(ent_b[i], cdb);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld  <= 1'b0;
            iss      <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            iss_vld  <= 1'b0;
            iss      <= '0;
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(load);
            if (load) begin
                iss_vld <= 1'b1;
                iss     <= '{tag: TAG_BASE | tag_t'(sel_idx), a: sel_a, b: sel_b};
            end else if (iss_rdy) begin
                iss_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tomasulo_rs_mpy.sv
// tb/tb_tomasulo_rs_mpy.sv - scoreboard testbench for tomasulo_rs_mpy
module tb_tomasulo_rs_mpy;
    import tomasulo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       disp_vld = 1'b0;
    operand_t   disp_a = '0;
    operand_t   disp_b = '0;
    logic       disp_rdy;
    tag_t       disp_tag;
    cdb_t       cdb = '0;
    logic       iss_vld;
    issue_t     iss;
    logic       iss_rdy = 1'b1;
    logic [2:0] busy_cnt;

    int     total = 0;
    int     bad   = 0;
    issue_t exp_q [$];
    issue_t mon_exp;

    tomasulo_rs_mpy #(.N(4), .RS_ID(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .disp_vld (disp_vld),
        .disp_a   (disp_a),
        .disp_b   (disp_b),
        .disp_rdy (disp_rdy),
        .disp_tag (disp_tag),
        .cdb      (cdb),
        .iss_vld  (iss_vld),
        .iss      (iss),
        .iss_rdy  (iss_rdy),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic operand_t mk(input logic r, input tag_t t, input word d);
        return '{rdy: r, tag: t, data: d};
    endfunction

    function automatic issue_t mk_iss(input tag_t t, input word a, input word b);
        return '{tag: t, a: a, b: b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input operand_t a, input operand_t b, input tag_t exp_tag);
        check("disp_rdy", 32'(disp_rdy), 32'd1);
        check("disp_tag", 32'(disp_tag), 32'(exp_tag));
        disp_a   = a;
        disp_b   = b;
        disp_vld = 1'b1;
        step();
        disp_vld = 1'b0;
        disp_a   = '0;
        disp_b   = '0;
    endtask

    task automatic cdb_pulse(input tag_t t, input word d);
        cdb = '{vld: 1'b1, tag: t, wdata: d};
        step();
        cdb = '0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d issues outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && iss_vld && iss_rdy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: got tag=%0h a=%0h b=%0h, required no issue",
                         iss.tag, iss.a, iss.b);
            end else begin
                mon_exp = exp_q.pop_front();
                if (iss !== mon_exp) begin
                    bad++;
                    $display("FAIL issue_payload: got tag=%0h a=%0h b=%0h required tag=%0h a=%0h b=%0h",
                             iss.tag, iss.a, iss.b, mon_exp.tag, mon_exp.a, mon_exp.b);
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_iss_vld", 32'(iss_vld), 32'd0);
        check("rst_busy", 32'(busy_cnt), 32'd0);
        check("rst_disp_rdy", 32'(disp_rdy), 32'd1);
        check("rst_disp_tag", 32'(disp_tag), 32'h04);
        check("rst_iss_tag", 32'(iss.tag), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Basic: both operands ready, two-cycle latency
        exp_q.push_back(mk_iss(6'h04, 32'd3, 32'd5));
        dispatch(mk(1'b1, 6'h00, 32'd3), mk(1'b1, 6'h00, 32'd5), 6'h04);
        check("basic_lat1_vld", 32'(iss_vld), 32'd0);
        check("basic_lat1_busy", 32'(busy_cnt), 32'd1);
        step();
        check("basic_lat2_vld", 32'(iss_vld), 32'd1);
        check("basic_lat2_busy", 32'(busy_cnt), 32'd0);
        step();
        check("basic_drop_vld", 32'(iss_vld), 32'd0);
        wait_drain(10);

        // Wakeup: operand A pending on tag 0x21
        exp_q.push_back(mk_iss(6'h04, 32'd9, 32'd7));
        dispatch(mk(1'b0, 6'h21, 32'd0), mk(1'b1, 6'h00, 32'd7), 6'h04);
        step();
        step();
        check("wake_pre_vld", 32'(iss_vld), 32'd0);
        cdb_pulse(6'h21, 32'd9);
        check("wake_c1_vld", 32'(iss_vld), 32'd0);
        step();
        check("wake_c2_vld", 32'(iss_vld), 32'd1);
        wait_drain(10);

        // Dispatch-cycle bypass; a later 0x22 broadcast must not disturb it
        exp_q.push_back(mk_iss(6'h04, 32'd4, 32'd6));
        cdb = '{vld: 1'b1, tag: 6'h22, wdata: 32'd4};
        dispatch(mk(1'b0, 6'h22, 32'd0), mk(1'b1, 6'h00, 32'd6), 6'h04);
        cdb = '{vld: 1'b1, tag: 6'h22, wdata: 32'd99};
        check("byp_t1_vld", 32'(iss_vld), 32'd0);
        step();
        cdb = '0;
        check("byp_t2_vld", 32'(iss_vld), 32'd1);
        wait_drain(10);

        // Full, free-then-reuse, oldest-first across non-index order, stall
        dispatch(mk(1'b0, 6'h30, 32'd0), mk(1'b1, 6'h00, 32'h100), 6'h04);
        dispatch(mk(1'b0, 6'h31, 32'd0), mk(1'b1, 6'h00, 32'h101), 6'h05);
        dispatch(mk(1'b0, 6'h32, 32'd0), mk(1'b1, 6'h00, 32'h102), 6'h06);
        dispatch(mk(1'b0, 6'h33, 32'd0), mk(1'b1, 6'h00, 32'h103), 6'h07);
        check("full_disp_rdy", 32'(disp_rdy), 32'd0);
        check("full_busy", 32'(busy_cnt), 32'd4);
        disp_a   = mk(1'b1, 6'h00, 32'hAA);
        disp_b   = mk(1'b1, 6'h00, 32'hBB);
        disp_vld = 1'b1;
        step();
        disp_vld = 1'b0;
        step();
        check("full_ignore_busy", 32'(busy_cnt), 32'd4);
        check("full_ignore_vld", 32'(iss_vld), 32'd0);
        iss_rdy = 1'b0;
        exp_q.push_back(mk_iss(6'h06, 32'h202, 32'h102));
        cdb_pulse(6'h32, 32'h202);
        check("free_same_cycle_rdy", 32'(disp_rdy), 32'd0);
        step();
        check("free_iss_vld", 32'(iss_vld), 32'd1);
        check("free_busy", 32'(busy_cnt), 32'd3);
        dispatch(mk(1'b0, 6'h34, 32'd0), mk(1'b1, 6'h00, 32'h104), 6'h06);
        cdb_pulse(6'h33, 32'h203);
        cdb_pulse(6'h31, 32'h201);
        cdb_pulse(6'h30, 32'h200);
        cdb_pulse(6'h34, 32'h204);
        exp_q.push_back(mk_iss(6'h04, 32'h200, 32'h100));
        exp_q.push_back(mk_iss(6'h05, 32'h201, 32'h101));
        exp_q.push_back(mk_iss(6'h07, 32'h203, 32'h103));
        exp_q.push_back(mk_iss(6'h06, 32'h204, 32'h104));
        for (int k = 0; k < 5; k++) begin
            check("stall_vld", 32'(iss_vld), 32'd1);
            check("stall_tag", 32'(iss.tag), 32'h06);
            check("stall_a", iss.a, 32'h202);
            step();
        end
        check("stall_busy", 32'(busy_cnt), 32'd4);
        iss_rdy = 1'b1;
        wait_drain(20);
        step();
        check("order_end_busy", 32'(busy_cnt), 32'd0);
        check("order_end_vld", 32'(iss_vld), 32'd0);

        // Flush with three valid entries and a held output
        iss_rdy = 1'b0;
        dispatch(mk(1'b1, 6'h00, 32'h11), mk(1'b1, 6'h00, 32'h12), 6'h04);
        dispatch(mk(1'b0, 6'h3A, 32'd0), mk(1'b1, 6'h00, 32'h13), 6'h05);
        dispatch(mk(1'b0, 6'h3A, 32'd0), mk(1'b1, 6'h00, 32'h14), 6'h04);
        dispatch(mk(1'b0, 6'h3A, 32'd0), mk(1'b1, 6'h00, 32'h15), 6'h06);
        check("pre_flush_busy", 32'(busy_cnt), 32'd3);
        check("pre_flush_vld", 32'(iss_vld), 32'd1);
        flush    = 1'b1;
        disp_a   = mk(1'b1, 6'h00, 32'h1);
        disp_b   = mk(1'b1, 6'h00, 32'h2);
        disp_vld = 1'b1;
        step();
        flush    = 1'b0;
        disp_vld = 1'b0;
        check("flush_vld", 32'(iss_vld), 32'd0);
        check("flush_busy", 32'(busy_cnt), 32'd0);
        check("flush_disp_rdy", 32'(disp_rdy), 32'd1);
        check("flush_disp_tag", 32'(disp_tag), 32'h04);
        iss_rdy = 1'b1;
        cdb_pulse(6'h3A, 32'h55);
        step();
        step();
        check("post_flush_vld", 32'(iss_vld), 32'd0);
        check("post_flush_busy", 32'(busy_cnt), 32'd0);

        // Asynchronous reset while an output is held under stall
        iss_rdy = 1'b0;
        dispatch(mk(1'b1, 6'h00, 32'h77), mk(1'b1, 6'h00, 32'h88), 6'h04);
        step();
        check("prerst_vld", 32'(iss_vld), 32'd1);
        check("prerst_a", iss.a, 32'h77);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_vld", 32'(iss_vld), 32'd0);
        check("async_rst_a", iss.a, 32'd0);
        check("async_rst_busy", 32'(busy_cnt), 32'd0);
        check("async_rst_disp_rdy", 32'(disp_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        iss_rdy = 1'b1;
        step();
        step();
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tomasulo_rs_mpy.md
Name: tomasulo_rs_mpy

Overview:
- Reservation station directly upstream of tomasulo_exe_mpy.
- Accepts dispatched multiply ops whose operands may still be pending, and snoops the CDB to capture pending operand values.
- Issues the oldest fully-ready entry to the multiplier as issue_t (tag, a, b), one per cycle, through a registered valid/ready output stage.
- Each entry's tag is the destination tag that the multiplier later broadcasts on the CDB.

Parameters:
- N: default 4. Number of RS entries, 2..16.
- RS_ID: default 1. Upper tag field identifying this station. Tag = {RS_ID, entry index}.
- IDX_W: default $clog2(N). Index width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low. Asserted (0) clears all state immediately.
- flush  in  1  synchronous clear of all entries and of the output stage.
- disp_vld  in  1  dispatch request.
- disp_a  in  operand_t  operand A: {rdy, tag, data}.
- disp_b  in  operand_t  operand B: {rdy, tag, data}.
- disp_rdy  out  1  at least one free entry; dispatch accepted when disp_vld & disp_rdy.
- disp_tag  out  TAG_W  tag that will be allocated; valid whenever disp_rdy is 1.
- cdb  in  cdb_t  completion bus: {vld, tag, wdata}.
- iss_vld  out  1  registered issue valid.
- iss  out  issue_t  registered issue payload: {tag, a, b}.
- iss_rdy  in  1  consumer accepts iss this cycle.
- busy_cnt  out  IDX_W+1  count of occupied entries (registered).

Behaviour:
- Reset (rst=0): all entries invalid, age matrix cleared, iss_vld=0, iss='0, busy_cnt=0. Consequently disp_rdy=1 and disp_tag={RS_ID,0}.
- Entry state: vld; per operand rdy/tag/data; age bits vs every other entry.
- Allocation: lowest-index entry with vld=0. disp_rdy=|~vld, evaluated on the registered valid vector. An entry freed this cycle is not reusable until the next cycle.
- Dispatch capture, per operand:
  - If disp_x.rdy=1, store data with rdy=1.
  - Else if cdb.vld and cdb.tag==disp_x.tag in the same cycle, store cdb.wdata with rdy=1 (dispatch-cycle bypass).
  - Else store tag with rdy=0.
- Wakeup: each valid entry with an operand at rdy=0 and a matching tag when cdb.vld=1 loads cdb.wdata and sets rdy=1. Both operands of one entry may wake on the same broadcast.
- Ready-for-select: vld & a.rdy & b.rdy, computed from registered state only.
  - A CDB wakeup makes the entry selectable the next cycle.
  - A newly dispatched entry is selectable no earlier than the next cycle.
  - Minimum dispatch-to-iss_vld latency, operands ready: 2 cycles (dispatch at cycle t, selected t+1, iss_vld visible t+2).
- Select: oldest ready entry, via an N x N age matrix.
  - On allocation of entry i, row i is set to "younger than all currently valid entries".
  - Ties cannot occur.
- Output stage: loads when (!iss_vld | iss_rdy) and a ready entry exists. The selected entry is freed in that same cycle.
  - Holds iss stable while iss_vld & !iss_rdy. Nothing is selected during the stall.
  - If nothing is ready and iss_rdy=1, iss_vld drops to 0 next cycle.
- Full: disp_rdy=0. A disp_vld while full is ignored, with no state change.
- Empty: no issue; iss drains normally.
- Simultaneous dispatch and issue-free in the same cycle: both happen. busy_cnt is net unchanged.
- Simultaneous events on the same entry: the freed entry is not the newly allocated one, because allocation uses the pre-free vector.
- flush: next cycle all entries are invalid, iss_vld=0, busy_cnt=0. A dispatch in the flush cycle is dropped. flush has priority over every other update.
- rst mid-operation: all state clears immediately, including an output held under stall.
- iss.tag = {RS_ID, idx}. Tags from other stations never match this station's entries except through operand tags.

Decomposition:
- tomasulo_pkg additions: operand_t {rdy, tag_t tag, logic [WORD_W-1:0] data}; issue_t {tag_t tag, word a, word b}. Reuse cdb_t, tag_t, TAG_W, WORD_W.
- Sub-module: tomasulo_age_select (N-entry age matrix plus oldest-ready one-hot picker), with ports: alloc one-hot, free one-hot, req vector, gnt one-hot.

Test Plan:
- Basic: after reset, dispatch a={1,-,3}, b={1,-,5} -> disp_tag={RS_ID,0}; iss_vld=1 two cycles later with iss.tag={1,0}, a=3, b=5; busy_cnt returns to 0.
- Wakeup: dispatch a={0,tag 0x21,-}, b={1,-,7}; 3 cycles later cdb {vld=1, tag=0x21, wdata=9} -> iss a=9, b=7 appears two cycles after the CDB cycle.
- Dispatch-cycle bypass: dispatch a={0,0x22} in the same cycle as cdb tag 0x22, wdata=4 -> entry ready, issues with a=4; a later 0x22 broadcast has no effect.
- Oldest-first and stall: fill 4 entries with pending operands, wake them in order 3,1,0,2 in one cycle, hold iss_rdy=0 for 5 cycles -> iss held constant; on release, issue order is dispatch order 0,1,2,3.
- Full: with 4 entries occupied, disp_rdy=0; a disp_vld is ignored. Freeing entry 2 -> next cycle disp_rdy=1 and disp_tag={1,2}.
- Flush and reset: flush with 3 entries valid and iss_vld=1 -> next cycle iss_vld=0 and busy_cnt=0. Drop rst mid-stall -> outputs zero immediately, without waiting for a clock edge.
